// File: rtl/fighter_pkg.sv
// fighter_pkg
// Shared definitions for the per-player action controller: the action state
// encoding seen by the sprite renderer, attack type codes and default frame
// counts. No ports; imported by player_input_fsm.
package fighter_pkg;

  // Action states; the numeric values are what state_o presents to the renderer
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_BLOCK    = 3'd1,
    ST_STARTUP  = 3'd2,
    ST_ACTIVE   = 3'd3,
    ST_RECOVERY = 3'd4,
    ST_STUN     = 3'd5
  } state_e;

  localparam logic [1:0] ATK_NONE  = 2'd0;
  localparam logic [1:0] ATK_PUNCH = 2'd1;
  localparam logic [1:0] ATK_KICK  = 2'd2;

  localparam int unsigned DEF_DB_CYCLES = 1_000_000;

  localparam logic [3:0] DEF_PUNCH_S     = 4'd2;
  localparam logic [3:0] DEF_PUNCH_A     = 4'd2;
  localparam logic [3:0] DEF_PUNCH_R     = 4'd4;
  localparam logic [3:0] DEF_KICK_S      = 4'd3;
  localparam logic [3:0] DEF_KICK_A      = 4'd3;
  localparam logic [3:0] DEF_KICK_R      = 4'd6;
  localparam logic [3:0] DEF_STUN_FRAMES = 4'd8;

  // A timed state of N frames loads N-1 and leaves on the frame where it reads 0
  function automatic logic [3:0] frameLoad(input logic [3:0] frames);
    return frames - 4'd1;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// button_debounce
// Two-flop synchroniser followed by a hold-time debouncer for one raw button.
// The debounced level only follows the synchronised level after the new value
// has been stable for DB_CYCLES consecutive clocks.
// Ports:
//   clk      - system clock
//   reset    - asynchronous, active-high
//   btn_i    - raw asynchronous button, active-high
//   level_o  - debounced button level
module button_debounce #(
  parameter int unsigned DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic level_o
);

  localparam int unsigned CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic [CW-1:0] cnt_q;

  // The counter only runs while the synchronised level disagrees with the
  // debounced one, so any bounce back to the old level restarts the hold time.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        level_q <= sync2_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/player_input_fsm.sv
// player_input_fsm
// Per-player action controller feeding the movement block. Debounces the five
// fighter buttons, latches punch/kick/hit requests between frame ticks and runs
// the idle/block/attack/stun state machine, advancing only on SCEN.
// Ports:
//   clk, reset             - system clock, asynchronous active-high reset
//   SCEN                   - frame tick, single-clock pulse
//   btn_left..btn_block    - raw asynchronous buttons, active-high
//   hit_in                 - single-clock pulse when the opponent's hitbox connects
//   move_left, move_right  - walk requests, only while IDLE
//   attack_active          - hitbox live (ACTIVE)
//   attack_type            - 0 none, 1 punch, 2 kick
//   block_active, stunned  - in BLOCK / in STUN
//   blocked_hit            - one-clock pulse after a hit is absorbed by block
//   state_o                - current state encoding for the sprite renderer
module player_input_fsm
  import fighter_pkg::*;
#(
  parameter int unsigned DB_CYCLES   = DEF_DB_CYCLES,
  parameter logic [3:0]  PUNCH_S     = DEF_PUNCH_S,
  parameter logic [3:0]  PUNCH_A     = DEF_PUNCH_A,
  parameter logic [3:0]  PUNCH_R     = DEF_PUNCH_R,
  parameter logic [3:0]  KICK_S      = DEF_KICK_S,
  parameter logic [3:0]  KICK_A      = DEF_KICK_A,
  parameter logic [3:0]  KICK_R      = DEF_KICK_R,
  parameter logic [3:0]  STUN_FRAMES = DEF_STUN_FRAMES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       SCEN,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_punch,
  input  logic       btn_kick,
  input  logic       btn_block,
  input  logic       hit_in,
  output logic       move_left,
  output logic       move_right,
  output logic       attack_active,
  output logic [1:0] attack_type,
  output logic       block_active,
  output logic       stunned,
  output logic       blocked_hit,
  output logic [2:0] state_o
);

  // Button bit positions: 0 left, 1 right, 2 punch, 3 kick, 4 block
  logic [4:0] rawBtn;
  logic [4:0] dbBtn;

  assign rawBtn = {btn_block, btn_kick, btn_punch, btn_right, btn_left};

  for (genvar i = 0; i < 5; i++) begin : g_db
    button_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk     (clk),
      .reset   (reset),
      .btn_i   (rawBtn[i]),
      .level_o (dbBtn[i])
    );
  end

  state_e     state_q, state_d;
  logic [1:0] atk_q, atk_d;
  logic [3:0] frameCnt_q, frameCnt_d;
  logic       punchReq_q, punchReq_d;
  logic       kickReq_q, kickReq_d;
  logic       hitReq_q, hitReq_d;
  logic       blockedHit_d;
  logic       dbPunchPrev_q, dbKickPrev_q;
  logic       attackActive_q, blockActive_q, stunned_q, blockedHit_q;
  logic       moveLeft_q, moveRight_q;
  logic       punchRise, kickRise;
  logic       arbitrate;

  assign punchRise = dbBtn[2] & ~dbPunchPrev_q;
  assign kickRise  = dbBtn[3] & ~dbKickPrev_q;

  always_comb begin
    state_d      = state_q;
    atk_d        = atk_q;
    frameCnt_d   = frameCnt_q;
    punchReq_d   = punchReq_q;
    kickReq_d    = kickReq_q;
    hitReq_d     = hitReq_q;
    blockedHit_d = 1'b0;
    arbitrate    = 1'b0;

    if (SCEN) begin
      hitReq_d = 1'b0;
      case (state_q)
        ST_IDLE, ST_BLOCK: begin
          if (hitReq_q) begin
            if (state_q == ST_BLOCK) begin
              blockedHit_d = 1'b1;
            end else begin
              state_d    = ST_STUN;
              atk_d      = ATK_NONE;
              frameCnt_d = frameLoad(STUN_FRAMES);
            end
          end else begin
            arbitrate = 1'b1;
          end
        end
        ST_STARTUP, ST_ACTIVE: begin
          punchReq_d = 1'b0;
          kickReq_d  = 1'b0;
          if (hitReq_q) begin
            state_d    = ST_STUN;
            atk_d      = ATK_NONE;
            frameCnt_d = frameLoad(STUN_FRAMES);
          end else if (frameCnt_q == 4'd0) begin
            if (state_q == ST_STARTUP) begin
              state_d    = ST_ACTIVE;
              frameCnt_d = frameLoad((atk_q == ATK_KICK) ? KICK_A : PUNCH_A);
            end else begin
              state_d    = ST_RECOVERY;
              frameCnt_d = frameLoad((atk_q == ATK_KICK) ? KICK_R : PUNCH_R);
            end
          end else begin
            frameCnt_d = frameCnt_q - 4'd1;
          end
        end
        ST_RECOVERY: begin
          // Presses are held through recovery so a combo can chain on exit
          if (hitReq_q) begin
            state_d    = ST_STUN;
            atk_d      = ATK_NONE;
            frameCnt_d = frameLoad(STUN_FRAMES);
            punchReq_d = 1'b0;
            kickReq_d  = 1'b0;
          end else if (frameCnt_q == 4'd0) begin
            arbitrate = 1'b1;
          end else begin
            frameCnt_d = frameCnt_q - 4'd1;
          end
        end
        ST_STUN: begin
          punchReq_d = 1'b0;
          kickReq_d  = 1'b0;
          if (frameCnt_q == 4'd0) begin
            state_d = dbBtn[4] ? ST_BLOCK : ST_IDLE;
            atk_d   = ATK_NONE;
          end else begin
            frameCnt_d = frameCnt_q - 4'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          atk_d   = ATK_NONE;
        end
      endcase

      // Free-state arbitration, shared by IDLE/BLOCK and the recovery exit
      if (arbitrate) begin
        if (kickReq_q) begin
          state_d    = ST_STARTUP;
          atk_d      = ATK_KICK;
          frameCnt_d = frameLoad(KICK_S);
          kickReq_d  = 1'b0;
        end else if (punchReq_q) begin
          state_d    = ST_STARTUP;
          atk_d      = ATK_PUNCH;
          frameCnt_d = frameLoad(PUNCH_S);
          punchReq_d = 1'b0;
        end else if (dbBtn[4]) begin
          state_d = ST_BLOCK;
          atk_d   = ATK_NONE;
        end else begin
          state_d = ST_IDLE;
          atk_d   = ATK_NONE;
        end
      end
    end

    // New events are applied after any clearing, so an event landing on the
    // SCEN clock survives to be consumed on the following SCEN.
    if (punchRise) punchReq_d = 1'b1;
    if (kickRise)  kickReq_d  = 1'b1;
    if (hit_in)    hitReq_d   = 1'b1;
  end

  // State, request flags and all outputs register together; status outputs
  // are decoded from the next state so they line up with state_o.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      atk_q          <= ATK_NONE;
      frameCnt_q     <= 4'd0;
      punchReq_q     <= 1'b0;
      kickReq_q      <= 1'b0;
      hitReq_q       <= 1'b0;
      dbPunchPrev_q  <= 1'b0;
      dbKickPrev_q   <= 1'b0;
      attackActive_q <= 1'b0;
      blockActive_q  <= 1'b0;
      stunned_q      <= 1'b0;
      blockedHit_q   <= 1'b0;
      moveLeft_q     <= 1'b0;
      moveRight_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      atk_q          <= atk_d;
      frameCnt_q     <= frameCnt_d;
      punchReq_q     <= punchReq_d;
      kickReq_q      <= kickReq_d;
      hitReq_q       <= hitReq_d;
      dbPunchPrev_q  <= dbBtn[2];
      dbKickPrev_q   <= dbBtn[3];
      attackActive_q <= (state_d == ST_ACTIVE);
      blockActive_q  <= (state_d == ST_BLOCK);
      stunned_q      <= (state_d == ST_STUN);
      blockedHit_q   <= blockedHit_d;
      moveLeft_q     <= dbBtn[0] & ~dbBtn[1] & (state_q == ST_IDLE);
      moveRight_q    <= dbBtn[1] & ~dbBtn[0] & (state_q == ST_IDLE);
    end
  end

  assign move_left     = moveLeft_q;
  assign move_right    = moveRight_q;
  assign attack_active = attackActive_q;
  assign attack_type   = atk_q;
  assign block_active  = blockActive_q;
  assign stunned       = stunned_q;
  assign blocked_hit   = blockedHit_q;
  assign state_o       = state_q;

endmodule
